// File: rtl/dna_mem_loader_pkg.sv
// Shared types and constants for the DNA memory-bank write loader.
package dna_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_READ,
    LOAD_REF,
    DONE
  } loader_state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Number of words held by one memory of mem_size bytes.
  function automatic int unsigned depth_words(input int unsigned mem_size);
    return mem_size / WORD_BYTES;
  endfunction

endpackage

// File: rtl/dna_mem_loader_if.sv
// Control, input stream and memory write-port bundle of the loader.
// slave is the loader's own view; master is the host/DMA + memory side.
interface dna_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_MATRIX   = 16
);
  logic                  start;
  logic                  clear_en;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] read_len;
  logic [ADDR_WIDTH-1:0] ref_len;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  we_read;
  logic [ADDR_WIDTH-1:0] addw_read;
  logic [DATA_WIDTH-1:0] din_read;
  logic                  we_ref;
  logic [ADDR_WIDTH-1:0] addw_ref;
  logic [DATA_WIDTH-1:0] din_ref;
  logic [N_MATRIX-1:0]   we_matrix;
  logic [ADDR_WIDTH-1:0] addw_matrix;

  modport master (
    output start, clear_en, abort, read_len, ref_len, s_valid, s_data,
    input  s_ready, busy, done, err, we_read, addw_read, din_read,
           we_ref, addw_ref, din_ref, we_matrix, addw_matrix
  );

  modport slave (
    input  start, clear_en, abort, read_len, ref_len, s_valid, s_data,
    output s_ready, busy, done, err, we_read, addw_read, din_read,
           we_ref, addw_ref, din_ref, we_matrix, addw_matrix
  );

endinterface

// File: rtl/dna_mem_loader_word_addr_cnt.sv
// Word counter shared by all loader phases; yields the byte address and a last-word flag.
module dna_mem_loader_word_addr_cnt
  import dna_mem_loader_pkg::*;
#(
  parameter int unsigned CntWidth  = 8,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [CntWidth-1:0]  limit_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 last_o
);

  logic [CntWidth-1:0] count_q, count_d;

  // Clear has priority so a phase change restarts at word 0.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign addr_o = AddrWidth'(count_q) << $clog2(WORD_BYTES);
  assign last_o = (count_q == limit_i - 1'b1);

endmodule

// File: rtl/dna_mem_loader.sv
// Write-side initiator for the DNA alignment memory bank: optional matrix clear,
// then streams read and ref words into their memories.
module dna_mem_loader
  import dna_mem_loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = 512,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_MATRIX   = 16
) (
  input logic             clk,
  input logic             rst_n,
  dna_mem_loader_if.slave bus
);

  localparam int unsigned DEPTH     = depth_words(MEM_SIZE);
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LEN = ADDR_WIDTH'(DEPTH);

  loader_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0]  read_len_q, read_len_d, ref_len_q, ref_len_d;
  logic                  quiet_q, quiet_d;  // length-error run: DONE without done pulse
  logic                  err_q, err_d;
  logic                  cnt_clr, cnt_inc, cnt_last;
  logic [CNT_WIDTH-1:0]  cnt_limit;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic                  len_bad, accept;
  logic                  we_read_q, we_ref_q;
  logic [ADDR_WIDTH-1:0] addw_read_q, addw_ref_q;
  logic [DATA_WIDTH-1:0] din_read_q, din_ref_q;

  assign len_bad = (bus.read_len > DEPTH_LEN) || (bus.ref_len > DEPTH_LEN);
  assign accept  = bus.s_ready && bus.s_valid;
  assign cnt_clr = (state_d != state_q);

  // Next-state, handshake and done generation.
  always_comb begin
    state_d     = state_q;
    read_len_d  = read_len_q;
    ref_len_d   = ref_len_q;
    quiet_d     = quiet_q;
    err_d       = err_q;
    cnt_inc     = 1'b0;
    cnt_limit   = DEPTH_CNT;
    bus.s_ready = 1'b0;
    bus.done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d      = len_bad;
          quiet_d    = len_bad;
          read_len_d = CNT_WIDTH'(bus.read_len);
          ref_len_d  = CNT_WIDTH'(bus.ref_len);
          if (len_bad)                   state_d = DONE;
          else if (bus.clear_en)         state_d = CLEAR;
          else if (bus.read_len != '0)   state_d = LOAD_READ;
          else if (bus.ref_len != '0)    state_d = LOAD_REF;
          else                           state_d = DONE;
        end
      end
      CLEAR: begin
        cnt_inc = 1'b1;
        if (cnt_last) begin
          if (read_len_q != '0)      state_d = LOAD_READ;
          else if (ref_len_q != '0)  state_d = LOAD_REF;
          else                       state_d = DONE;
        end
      end
      LOAD_READ: begin
        cnt_limit   = read_len_q;
        bus.s_ready = 1'b1;
        cnt_inc     = bus.s_valid;
        if (bus.s_valid && cnt_last) begin
          state_d = (ref_len_q != '0) ? LOAD_REF : DONE;
        end
      end
      LOAD_REF: begin
        cnt_limit   = ref_len_q;
        bus.s_ready = 1'b1;
        cnt_inc     = bus.s_valid;
        if (bus.s_valid && cnt_last) state_d = DONE;
      end
      DONE: begin
        bus.done = !quiet_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins immediately: no new accept, no done, back to IDLE.
    if (bus.abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      err_d       = 1'b1;
      cnt_inc     = 1'b0;
      bus.s_ready = 1'b0;
      bus.done    = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      read_len_q <= '0;
      ref_len_q  <= '0;
      quiet_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_len_q <= read_len_d;
      ref_len_q  <= ref_len_d;
      quiet_q    <= quiet_d;
      err_q      <= err_d;
    end
  end

  // Registered memory writes, one cycle after each accepted word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_read_q   <= 1'b0;
      addw_read_q <= '0;
      din_read_q  <= '0;
      we_ref_q    <= 1'b0;
      addw_ref_q  <= '0;
      din_ref_q   <= '0;
    end else begin
      we_read_q <= accept && (state_q == LOAD_READ);
      we_ref_q  <= accept && (state_q == LOAD_REF);
      if (accept && (state_q == LOAD_READ)) begin
        addw_read_q <= cnt_addr;
        din_read_q  <= bus.s_data;
      end
      if (accept && (state_q == LOAD_REF)) begin
        addw_ref_q <= cnt_addr;
        din_ref_q  <= bus.s_data;
      end
    end
  end

  dna_mem_loader_word_addr_cnt #(
    .CntWidth  (CNT_WIDTH),
    .AddrWidth (ADDR_WIDTH)
  ) u_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .limit_i (cnt_limit),
    .addr_o  (cnt_addr),
    .last_o  (cnt_last)
  );

  assign bus.busy        = (state_q != IDLE);
  assign bus.err         = err_q;
  assign bus.we_read     = we_read_q;
  assign bus.addw_read   = addw_read_q;
  assign bus.din_read    = din_read_q;
  assign bus.we_ref      = we_ref_q;
  assign bus.addw_ref    = addw_ref_q;
  assign bus.din_ref     = din_ref_q;
  assign bus.we_matrix   = {N_MATRIX{(state_q == CLEAR) && !bus.abort}};
  assign bus.addw_matrix = (state_q == CLEAR) ? cnt_addr : '0;

endmodule

// File: tb/tb_dna_mem_loader.sv
// Randomized self-checking bench for dna_mem_loader with a transaction-level model.
module tb_dna_mem_loader;
  import dna_mem_loader_pkg::*;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NM = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dna_mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_MATRIX(NM)) bus ();

  dna_mem_loader #(
    .MEM_SIZE   (512),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .N_MATRIX   (NM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: remaining words per phase, plus the writes owed for the next cycle.
  bit          m_on = 1'b0;
  bit          m_active, m_final, m_ok, m_err;
  int          m_clear_left, m_read_left, m_ref_left, m_rlen, m_flen;
  bit          m_wr_r, m_wr_f;
  logic [31:0] m_wr_r_addr, m_wr_r_data, m_wr_f_addr, m_wr_f_data;

  initial begin : compare
    bit in_clear, in_read, in_ref, e_rdy, acc, bad;
    forever begin
      @(negedge clk);
      if (m_on) begin
        in_clear = m_active && !m_final && (m_clear_left > 0);
        in_read  = m_active && !m_final && (m_clear_left == 0) && (m_read_left > 0);
        in_ref   = m_active && !m_final && (m_clear_left == 0) && (m_read_left == 0)
                   && (m_ref_left > 0);
        e_rdy    = (in_read || in_ref) && !bus.abort;
        chk("busy", bus.busy, m_active);
        chk("s_ready", bus.s_ready, e_rdy);
        chk("done", bus.done, m_final && m_ok && !bus.abort);
        chk("err", bus.err, m_err);
        chk("we_matrix", bus.we_matrix, (in_clear && !bus.abort) ? 32'hFFFF : 32'h0);
        chk("addw_matrix", bus.addw_matrix,
            in_clear ? 32'((DEPTH - m_clear_left) * 4) : 32'h0);
        chk("we_read", bus.we_read, m_wr_r);
        if (m_wr_r) begin
          chk("addw_read", bus.addw_read, m_wr_r_addr);
          chk("din_read", bus.din_read, m_wr_r_data);
        end
        chk("we_ref", bus.we_ref, m_wr_f);
        if (m_wr_f) begin
          chk("addw_ref", bus.addw_ref, m_wr_f_addr);
          chk("din_ref", bus.din_ref, m_wr_f_data);
        end
        // Advance the model across the coming edge.
        acc = e_rdy && bus.s_valid;
        if (!rst_n) begin
          m_active = 0; m_final = 0; m_ok = 0; m_err = 0;
          m_clear_left = 0; m_read_left = 0; m_ref_left = 0;
          m_wr_r = 0; m_wr_f = 0;
        end else begin
          m_wr_r      = in_read && acc;
          m_wr_r_addr = 32'((m_rlen - m_read_left) * 4);
          m_wr_r_data = bus.s_data;
          m_wr_f      = in_ref && acc;
          m_wr_f_addr = 32'((m_flen - m_ref_left) * 4);
          m_wr_f_data = bus.s_data;
          if (!m_active) begin
            if (bus.start) begin
              bad      = (bus.read_len > 32'(DEPTH)) || (bus.ref_len > 32'(DEPTH));
              m_active = 1;
              m_err    = bad;
              m_ok     = !bad;
              if (bad) begin
                m_clear_left = 0; m_read_left = 0; m_ref_left = 0;
              end else begin
                m_clear_left = bus.clear_en ? DEPTH : 0;
                m_read_left  = int'(bus.read_len);
                m_ref_left   = int'(bus.ref_len);
              end
              m_rlen  = m_read_left;
              m_flen  = m_ref_left;
              m_final = (m_clear_left + m_read_left + m_ref_left) == 0;
            end
          end else if (bus.abort) begin
            m_active = 0; m_final = 0; m_err = 1;
          end else if (m_final) begin
            m_active = 0; m_final = 0;
          end else begin
            if (in_clear) m_clear_left--;
            else if (acc && in_read) m_read_left--;
            else if (acc && in_ref) m_ref_left--;
            m_final = (m_clear_left + m_read_left + m_ref_left) == 0;
          end
        end
      end
    end
  end

  // Observed memory image and per-operation statistics.
  logic [31:0] mem_read [DEPTH];
  logic [31:0] mem_ref  [DEPTH];
  logic [31:0] rd_addrs [$];
  int          clr_cycles, n_ref_wr, done_cnt;
  logic [31:0] first_clr_addr, last_clr_addr;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (m_on) begin
        if (bus.we_matrix == '1) begin
          if (clr_cycles == 0) first_clr_addr = bus.addw_matrix;
          last_clr_addr = bus.addw_matrix;
          clr_cycles++;
        end
        if (bus.we_read) begin
          mem_read[bus.addw_read[8:2]] = bus.din_read;
          rd_addrs.push_back(bus.addw_read);
        end
        if (bus.we_ref) begin
          mem_ref[bus.addw_ref[8:2]] = bus.din_ref;
          n_ref_wr++;
        end
        if (bus.done) done_cnt++;
      end
    end
  end

  // Drives one operation; vmode 0 = valid held, 1 = 1010.., 2 = random.
  task automatic run_op(input bit clr, input logic [31:0] rl, input logic [31:0] fl,
                        input int vmode, input bit seq, input logic [31:0] dbase,
                        input int abort_at, input int restart_at, input int rst_at,
                        output int ncyc);
    bit hs, idle, fin;
    int wn;
    wn = 0; fin = 0; ncyc = -1;
    rd_addrs.delete();
    clr_cycles = 0; n_ref_wr = 0; done_cnt = 0;
    bus.start = 1; bus.clear_en = clr; bus.read_len = rl; bus.ref_len = fl;
    bus.s_valid = (vmode == 0); bus.s_data = seq ? dbase : $urandom;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      hs   = bus.s_valid && bus.s_ready;
      idle = (c > 0) && !bus.busy;
      @(posedge clk); #1;
      bus.start = 0; bus.abort = 0; rst_n = 1;
      bus.clear_en = 1'($urandom_range(1));
      bus.read_len = $urandom; bus.ref_len = $urandom;
      if (idle) begin
        fin = 1; ncyc = c;
        break;
      end
      if (hs) wn++;
      if (c + 1 == abort_at) bus.abort = 1;
      if (c + 1 == restart_at) bus.start = 1;
      if (c + 1 == rst_at) rst_n = 0;
      case (vmode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = ((c + 1) % 2) == 1;
        default: bus.s_valid = 1'($urandom_range(1));
      endcase
      bus.s_data = seq ? dbase + 32'(wn) : $urandom;
    end
    chk("idle_within_budget", {31'b0, fin}, 32'h1);
  endtask

  initial begin : driver
    int n;
    logic [31:0] rl, fl;
    rst_n = 0;
    bus.start = 0; bus.clear_en = 0; bus.abort = 0; bus.read_len = 0; bus.ref_len = 0;
    bus.s_valid = 0; bus.s_data = 0;
    repeat (3) @(posedge clk);
    #1; m_on = 1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);        chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_done", bus.done, 0);        chk("rst_err", bus.err, 0);
    chk("rst_we_read", bus.we_read, 0);  chk("rst_we_ref", bus.we_ref, 0);
    chk("rst_we_matrix", bus.we_matrix, 0);
    chk("rst_addw_read", bus.addw_read, 0); chk("rst_din_read", bus.din_read, 0);
    chk("rst_addw_ref", bus.addw_ref, 0);   chk("rst_din_ref", bus.din_ref, 0);
    chk("rst_addw_matrix", bus.addw_matrix, 0);
    @(posedge clk); #1; rst_n = 1;

    // Clear then 3 read + 2 ref words, no gaps.
    run_op(1, 3, 2, 0, 1, 32'hA0, -1, -1, -1, n);
    chk("t1_cycles", n, 135);            chk("t1_clr_cycles", clr_cycles, 128);
    chk("t1_first_clr", first_clr_addr, 32'h0);
    chk("t1_last_clr", last_clr_addr, 32'h1FC);
    chk("t1_read0", mem_read[0], 32'hA0); chk("t1_read1", mem_read[1], 32'hA1);
    chk("t1_read2", mem_read[2], 32'hA2); chk("t1_ref0", mem_ref[0], 32'hA3);
    chk("t1_ref1", mem_ref[1], 32'hA4);   chk("t1_ref_writes", n_ref_wr, 2);
    chk("t1_done", done_cnt, 1);

    // Oversized read length.
    run_op(0, 129, 2, 0, 1, 32'hB0, -1, -1, -1, n);
    chk("t2_cycles", n, 2);               chk("t2_err", bus.err, 1);
    chk("t2_done", done_cnt, 0);
    chk("t2_writes", 32'(rd_addrs.size() + n_ref_wr + clr_cycles), 0);

    // Gappy stream, read only.
    run_op(0, 4, 0, 1, 1, 32'hC0, -1, -1, -1, n);
    chk("t3_nwrites", 32'(rd_addrs.size()), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_addr%0d", k), (rd_addrs.size() > k) ? rd_addrs[k] : 32'hFFFF_FFFF,
          32'(4 * k));
    chk("t3_ref_writes", n_ref_wr, 0);    chk("t3_done", done_cnt, 1);
    chk("t3_err_cleared", bus.err, 0);

    // Abort two cycles into the ref phase, then a normal run.
    run_op(0, 3, 4, 0, 1, 32'hD0, 6, -1, -1, n);
    chk("t4_cycles", n, 7);               chk("t4_err", bus.err, 1);
    chk("t4_done", done_cnt, 0);          chk("t4_ref_writes", n_ref_wr, 2);
    run_op(0, 2, 1, 0, 1, 32'hD8, -1, -1, -1, n);
    chk("t4b_err", bus.err, 0);           chk("t4b_done", done_cnt, 1);

    // Start re-pulsed while busy must be ignored.
    run_op(1, 3, 2, 0, 1, 32'hA0, -1, 10, -1, n);
    chk("t5_cycles", n, 135);             chk("t5_clr_cycles", clr_cycles, 128);
    chk("t5_read2", mem_read[2], 32'hA2); chk("t5_ref1", mem_ref[1], 32'hA4);
    chk("t5_done", done_cnt, 1);

    // Reset pulse in the middle of the clear phase.
    run_op(1, 3, 2, 0, 1, 32'hE0, -1, -1, 50, n);
    chk("t6_cycles", n, 51);              chk("t6_clr_cycles", clr_cycles, 50);
    chk("t6_done", done_cnt, 0);

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      rl = ($urandom_range(9) == 0) ? 32'(129 + $urandom_range(1000)) : 32'($urandom_range(10));
      fl = ($urandom_range(9) == 0) ? 32'(129 + $urandom_range(1000)) : 32'($urandom_range(10));
      run_op(($urandom_range(3) == 0), rl, fl, int'($urandom_range(2)), 0, 32'h0,
             ($urandom_range(4) == 0) ? int'($urandom_range(1, 15)) : -1,
             ($urandom_range(4) == 0) ? int'($urandom_range(1, 10)) : -1, -1, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
